// File: rtl/acc_sum_differentiator_if.sv
// Valid/ready stream bundle: master drives data/valid, slave drives ready.
interface acc_sum_differentiator_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/acc_sum_differentiator.sv
// Recovers accumulator input samples from a running-sum stream by first difference,
// with a 1-entry output register and a sticky range-error state.
module acc_sum_differentiator #(
    parameter int unsigned SUM_W     = 21,
    parameter int unsigned SAMPLE_W  = 13,
    parameter bit          ZERO_BASE = 1'b1,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce_i,
    input  logic                          clear_i,
    acc_sum_differentiator_if.slave       sum_if,
    acc_sum_differentiator_if.master      sample_if,
    output logic                          range_err_o,
    output logic [ERRCNT_W-1:0]           err_count_o
);

    typedef enum logic [1:0] {PRIME, RUN, ERROR} state_t;

    localparam state_t BASE_STATE = ZERO_BASE ? RUN : PRIME;

    state_t                state_q, state_d;
    logic [SUM_W-1:0]      prev_q, prev_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  range_err_q, range_err_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                  sum_ready;
    logic                  accept;
    logic                  consume;
    logic [SUM_W-1:0]      diff;
    logic                  in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BASE_STATE;
            prev_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        range_err_d = range_err_q;
        err_cnt_d   = err_cnt_q;

        sum_ready = ce_i && (state_q != ERROR) && (!valid_q || sample_if.ready);
        // clear wins over any handshake presented in the same cycle
        accept    = sum_if.valid && sum_ready && !clear_i;
        consume   = valid_q && sample_if.ready && ce_i;
        diff      = sum_if.data - prev_q;
        in_range  = (diff[SUM_W-1:SAMPLE_W] == '0);

        if (clear_i) begin
            prev_d      = '0;
            valid_d     = 1'b0;
            range_err_d = 1'b0;
            state_d     = BASE_STATE;
        end else begin
            if (consume) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                case (state_q)
                    PRIME: begin
                        prev_d  = sum_if.data;
                        state_d = RUN;
                    end
                    RUN: begin
                        prev_d = sum_if.data;
                        if (in_range) begin
                            sample_d = diff[SAMPLE_W-1:0];
                            valid_d  = 1'b1;
                        end else begin
                            range_err_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                            end
                            state_d = ERROR;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign sum_if.ready     = sum_ready;
    assign sample_if.data   = sample_q;
    assign sample_if.valid  = valid_q;
    assign range_err_o      = range_err_q;
    assign err_count_o      = err_cnt_q;

endmodule
